sa_load_seq: RTL and testbench
==============================

// Module: sa_load_seq
// PURPOSE
//  Parametrised load sequencer for the systolic conv array. Replaces the hand-timed
//  counter/enable stimulus with a start/done controlled FSM. Per channel it streams
//  K*K weights (w_load) and then N*N pixels (i_load), with addresses for the W/I
//  memories. Multi-channel runs and run-time kernel/image sizes are supported.
// PARAMETERS
//  ADDR_W    16  width of w_addr / i_addr
//  SIZE_W     8  width of img_size / ker_size
//  CH_W       4  width of num_ch; up to 2**CH_W-1 channels
//  GAP_CYC    2  idle cycles between the last weight and the first pixel (>=1)
//  DRAIN_CYC  4  idle cycles after the last pixel of a channel (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       begin a run; sampled only in IDLE
//  abort      in   1       synchronous cancel of a run
//  img_size   in   SIZE_W  N, image edge length
//  ker_size   in   SIZE_W  K, kernel edge length
//  num_ch     in   CH_W    channel count C
//  busy       out  1       high from the cycle after start until done or abort
//  done       out  1       one-cycle pulse at the end of a successful run
//  cfg_err    out  1       one-cycle pulse when start is rejected
//  w_load     out  1       weight-valid strobe to the array
//  i_load     out  1       input-valid strobe to the array
//  w_addr     out  ADDR_W  weight memory address
//  i_addr     out  ADDR_W  input memory address
//  ch_idx     out  CH_W    current channel, 0..C-1
// BEHAVIOUR
//  Reset: every output is 0 and the state is IDLE.
//  Configuration:
//   - On start in IDLE, latch N, K, C.
//   - If K==0, N==0, C==0 or K>N: pulse cfg_err, stay in IDLE, no busy.
//  FSM sequence: IDLE -> WLD -> GAP -> ILD -> DRN
//   - From DRN: go to WLD if ch_idx<C-1, otherwise go to DONE.
//   - DONE -> IDLE.
//  WLD: exactly K*K cycles.
//   - w_load=1.
//   - w_addr = ch_idx*K*K + j, j=0..K*K-1.
//  GAP: GAP_CYC cycles, with w_load=0 and i_load=0.
//  ILD: exactly N*N cycles.
//   - i_load=1.
//   - i_addr = ch_idx*N*N + j, j=0..N*N-1.
//  DRN: DRAIN_CYC cycles. At its end ch_idx increments.
//  Channel base addresses:
//   - Kept as running bases. Add K*K or N*N when the channel ends. No multiplier.
//   - K*K and N*N are computed once at start with a shift-add.
//  Addresses:
//   - Hold their last value while idle or strobes are low.
//   - Wrap modulo 2**ADDR_W.
//  DONE: done=1 for one cycle and busy=0. start is accepted again on the next cycle.
//  start while busy is ignored. Config inputs are ignored while busy.
//  abort (priority over start; at DONE, done takes precedence over abort):
//   - Next cycle: state IDLE, strobes 0, busy 0, ch_idx 0, no done pulse.
//   - Address outputs hold.
//  rst_n low mid-run: immediate return to the reset state. No done pulse.
//  Latency: first w_load is 1 cycle after start is sampled.
//  Run length (start edge to done): C*(K*K+GAP_CYC+N*N+DRAIN_CYC)+1 cycles.
// CONFIGURATION
//  SA_LOAD_PERF_EN defined:
//   - Adds output perf_cyc [31:0] (saturating).
//   - Cleared on accepted start; counts every busy cycle.
//   - Holds its value after done or abort.
//  SA_LOAD_PERF_EN undefined: port absent, no counter logic.
// TESTING
//  1 N=14,K=3,C=1: w_load 9 cycles with w_addr 0..8; 2 gap cycles;
//    i_load 196 cycles with i_addr 0..195; done at cycle 212.
//  2 N=4,K=2,C=3: w_addr 0-3/4-7/8-11; i_addr 0-15/16-31/32-47;
//    ch_idx 0,1,2; one done pulse at cycle 79.
//  3 Bad config K=5,N=4, and C=0: cfg_err pulse, busy stays 0, no strobes.
//  4 abort during ILD at i_addr=50 (N=14,K=3,C=1): next cycle i_load=0, busy=0,
//    no done; a new start then runs case 1 exactly.
//  5 start pulsed mid-run, and rst_n low mid-WLD: start ignored; after reset all
//    outputs are 0 and the state is IDLE.
//  6 SA_LOAD_PERF_EN defined, case 1: perf_cyc=212 after done and holds.

Source files
------------

// File: rtl/sa_load_seq_if.sv
// -----------------------------------------------------------------------------
// sa_load_seq_if
// Handshake/control bundle between a run controller and the systolic-array
// load sequencer.
//   master : drives start/abort and the run configuration, observes status,
//            strobes and addresses.
//   slave  : the sequencer side (sa_load_seq).
// Signals:
//   start, abort            run control
//   img_size, ker_size      N and K edge lengths (SIZE_W)
//   num_ch                  channel count C (CH_W)
//   busy, done, cfg_err     run status
//   w_load, w_addr          weight strobe / address (ADDR_W)
//   i_load, i_addr          pixel strobe / address (ADDR_W)
//   ch_idx                  current channel
//   perf_cyc                busy-cycle counter, present only with SA_LOAD_PERF_EN
// -----------------------------------------------------------------------------
interface sa_load_seq_if #(
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 8,
    parameter int CH_W   = 4
);
    logic              start;
    logic              abort;
    logic [SIZE_W-1:0] img_size;
    logic [SIZE_W-1:0] ker_size;
    logic [CH_W-1:0]   num_ch;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              w_load;
    logic              i_load;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] i_addr;
    logic [CH_W-1:0]   ch_idx;
`ifdef SA_LOAD_PERF_EN
    logic [31:0]       perf_cyc;
`endif

    modport master (
        output start, abort, img_size, ker_size, num_ch,
        input  busy, done, cfg_err, w_load, i_load, w_addr, i_addr, ch_idx
`ifdef SA_LOAD_PERF_EN
        , input perf_cyc
`endif
    );

    modport slave (
        input  start, abort, img_size, ker_size, num_ch,
        output busy, done, cfg_err, w_load, i_load, w_addr, i_addr, ch_idx
`ifdef SA_LOAD_PERF_EN
        , output perf_cyc
`endif
    );
endinterface

// File: rtl/sa_load_seq.sv
// -----------------------------------------------------------------------------
// sa_load_seq
// Start/done controlled load sequencer for the systolic conv array. For every
// channel it streams K*K weights (w_load/w_addr), waits GAP_CYC cycles, streams
// N*N pixels (i_load/i_addr) and then drains for DRAIN_CYC cycles.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     sa_load_seq_if.slave (start/abort/config in, status/strobes out)
// Optional feature macro: SA_LOAD_PERF_EN adds bus.perf_cyc, a saturating
// count of busy cycles, cleared on an accepted start.
// A one-cycle SETUP state follows an accepted start: it holds the latched
// K*K / N*N squares (built by shift-add) before the first weight strobe, so
// a run lasts C*(K*K+GAP_CYC+N*N+DRAIN_CYC)+1 cycles from start to done.
// -----------------------------------------------------------------------------
module sa_load_seq #(
    parameter int ADDR_W    = 16,
    parameter int SIZE_W    = 8,
    parameter int CH_W      = 4,
    parameter int GAP_CYC   = 2,
    parameter int DRAIN_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sa_load_seq_if.slave  bus
);
    localparam int SQ_W = 2 * SIZE_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WLD   = 3'd2,
        S_GAP   = 3'd3,
        S_ILD   = 3'd4,
        S_DRN   = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    // Square of an edge length using shifted partial sums only.
    function automatic logic [SQ_W-1:0] sq_shift_add(input logic [SIZE_W-1:0] v);
        logic [SQ_W-1:0] acc;
        logic [SQ_W-1:0] ext;
        acc = '0;
        ext = {{SIZE_W{1'b0}}, v};
        for (int b = 0; b < SIZE_W; b++) begin
            if (v[b]) begin
                acc = acc + (ext << b);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_e            state_q, state_d;
    logic [SQ_W-1:0]   cnt_q, cnt_d;
    logic [SQ_W-1:0]   kk_q, kk_d;
    logic [SQ_W-1:0]   nn_q, nn_d;
    logic [CH_W-1:0]   c_q, c_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] i_base_q, i_base_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic              w_load_q, w_load_d;
    logic              i_load_q, i_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
`ifdef SA_LOAD_PERF_EN
    logic [31:0]       perf_q, perf_d;
`endif

    logic cfg_bad_s;
    logic start_ok_s;
    logic abort_s;

    assign cfg_bad_s  = (bus.ker_size == '0) || (bus.img_size == '0) ||
                        (bus.num_ch == '0) || (bus.ker_size > bus.img_size);
    // abort outranks start in IDLE, so a simultaneous abort blocks the run
    assign start_ok_s = (state_q == S_IDLE) && bus.start && !bus.abort && !cfg_bad_s;
    // busy is high exactly in SETUP..DRN; DONE is not abortable
    assign abort_s    = busy_q && bus.abort;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kk_d      = kk_q;
        nn_d      = nn_q;
        c_d       = c_q;
        ch_idx_d  = ch_idx_q;
        w_base_d  = w_base_q;
        i_base_d  = i_base_q;
        w_addr_d  = w_addr_q;
        i_addr_d  = i_addr_q;
        w_load_d  = w_load_q;
        i_load_d  = i_load_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        if (abort_s) begin
            // addresses deliberately keep their last value
            state_d  = S_IDLE;
            cnt_d    = '0;
            w_load_d = 1'b0;
            i_load_d = 1'b0;
            busy_d   = 1'b0;
            ch_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok_s) begin
                        state_d  = S_SETUP;
                        busy_d   = 1'b1;
                        kk_d     = sq_shift_add(bus.ker_size);
                        nn_d     = sq_shift_add(bus.img_size);
                        c_d      = bus.num_ch;
                        ch_idx_d = '0;
                        w_base_d = '0;
                        i_base_d = '0;
                        cnt_d    = '0;
                    end else if (bus.start && !bus.abort) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SETUP: begin
                    state_d  = S_WLD;
                    w_load_d = 1'b1;
                    w_addr_d = w_base_q;
                    cnt_d    = '0;
                end
                S_WLD: begin
                    if (cnt_q == kk_q - SQ_W'(1)) begin
                        state_d  = S_GAP;
                        cnt_d    = '0;
                        w_load_d = 1'b0;
                        w_base_d = w_base_q + ADDR_W'(kk_q);
                    end else begin
                        cnt_d    = cnt_q + SQ_W'(1);
                        w_addr_d = w_addr_q + ADDR_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == SQ_W'(GAP_CYC - 1)) begin
                        state_d  = S_ILD;
                        cnt_d    = '0;
                        i_load_d = 1'b1;
                        i_addr_d = i_base_q;
                    end else begin
                        cnt_d = cnt_q + SQ_W'(1);
                    end
                end
                S_ILD: begin
                    if (cnt_q == nn_q - SQ_W'(1)) begin
                        state_d  = S_DRN;
                        cnt_d    = '0;
                        i_load_d = 1'b0;
                        i_base_d = i_base_q + ADDR_W'(nn_q);
                    end else begin
                        cnt_d    = cnt_q + SQ_W'(1);
                        i_addr_d = i_addr_q + ADDR_W'(1);
                    end
                end
                S_DRN: begin
                    if (cnt_q == SQ_W'(DRAIN_CYC - 1)) begin
                        cnt_d = '0;
                        if (ch_idx_q < c_q - CH_W'(1)) begin
                            state_d  = S_WLD;
                            ch_idx_d = ch_idx_q + CH_W'(1);
                            w_load_d = 1'b1;
                            w_addr_d = w_base_q;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + SQ_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    w_load_d = 1'b0;
                    i_load_d = 1'b0;
                    busy_d   = 1'b0;
                    ch_idx_d = '0;
                end
            endcase
        end

`ifdef SA_LOAD_PERF_EN
        if (start_ok_s) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
`endif
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            kk_q      <= '0;
            nn_q      <= '0;
            c_q       <= '0;
            ch_idx_q  <= '0;
            w_base_q  <= '0;
            i_base_q  <= '0;
            w_addr_q  <= '0;
            i_addr_q  <= '0;
            w_load_q  <= 1'b0;
            i_load_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef SA_LOAD_PERF_EN
            perf_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kk_q      <= kk_d;
            nn_q      <= nn_d;
            c_q       <= c_d;
            ch_idx_q  <= ch_idx_d;
            w_base_q  <= w_base_d;
            i_base_q  <= i_base_d;
            w_addr_q  <= w_addr_d;
            i_addr_q  <= i_addr_d;
            w_load_q  <= w_load_d;
            i_load_q  <= i_load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
`ifdef SA_LOAD_PERF_EN
            perf_q    <= perf_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;
    assign bus.w_load  = w_load_q;
    assign bus.i_load  = i_load_q;
    assign bus.w_addr  = w_addr_q;
    assign bus.i_addr  = i_addr_q;
    assign bus.ch_idx  = ch_idx_q;
`ifdef SA_LOAD_PERF_EN
    assign bus.perf_cyc = perf_q;
`endif

endmodule

// File: tb/tb_sa_load_seq.sv
// -----------------------------------------------------------------------------
// tb_sa_load_seq
// Scoreboard bench for sa_load_seq. Each issued run pushes the expected
// strobe/done/cfg_err events (kind, address, channel, cycle) into a queue; a
// negedge monitor pops and compares every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_sa_load_seq;
    localparam int GAP   = 2;
    localparam int DRAIN = 4;
    localparam int NOLIM = 1000000;

    localparam int K_W = 0;
    localparam int K_I = 1;
    localparam int K_D = 2;
    localparam int K_E = 3;

    typedef struct {
        int kind;
        int addr;
        int ch;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    sa_load_seq_if #(.ADDR_W(16), .SIZE_W(8), .CH_W(4)) bus ();

    sa_load_seq #(
        .ADDR_W(16), .SIZE_W(8), .CH_W(4), .GAP_CYC(GAP), .DRAIN_CYC(DRAIN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycle index: value equals the number of rising edges seen so far
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check_event(input int kind, input int addr, input int ch);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d addr %0d ch %0d at cycle %0d, expected none",
                     kind, addr, ch, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                ((kind == K_W || kind == K_I) && (e.addr != addr || e.ch != ch))) begin
                $display("FAIL event: got kind %0d addr %0d ch %0d cycle %0d, expected kind %0d addr %0d ch %0d cycle %0d",
                         kind, addr, ch, cyc, e.kind, e.addr, e.ch, e.cyc);
            end else begin
                n_pass++;
            end
        end
    endtask

    // monitor: every presented output event is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.w_load)  check_event(K_W, int'(bus.w_addr), int'(bus.ch_idx));
            if (bus.i_load)  check_event(K_I, int'(bus.i_addr), int'(bus.ch_idx));
            if (bus.done)    check_event(K_D, 0, 0);
            if (bus.cfg_err) check_event(K_E, 0, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_ev(input int kind, input int addr, input int ch, input int t);
        exp_t e;
        e.kind = kind;
        e.addr = addr % 65536;
        e.ch   = ch;
        e.cyc  = t;
        sb.push_back(e);
    endtask

    // expected events of a good run whose start is sampled at edge s; events
    // after cycle lim are not expected (abort / reset cut the run short)
    task automatic push_run(input int s, input int n, input int k, input int c, input int lim);
        int t;
        int wb;
        int ib;
        t  = s + 1;
        wb = 0;
        ib = 0;
        for (int ch = 0; ch < c; ch++) begin
            for (int j = 0; j < k * k; j++) begin
                if (t <= lim) push_ev(K_W, wb + j, ch, t);
                t++;
            end
            wb += k * k;
            t  += GAP;
            for (int j = 0; j < n * n; j++) begin
                if (t <= lim) push_ev(K_I, ib + j, ch, t);
                t++;
            end
            ib += n * n;
            t  += DRAIN;
        end
        if (t <= lim) push_ev(K_D, 0, 0, t);
    endtask

    // called right after tick(); start is sampled on the next edge
    task automatic start_run(input int n, input int k, input int c, input bit bad,
                             input int lim_off, output int s);
        bus.img_size = 8'(n);
        bus.ker_size = 8'(k);
        bus.num_ch   = 4'(c);
        bus.start    = 1'b1;
        s = cyc + 1;
        if (bad) push_ev(K_E, 0, 0, s);
        else     push_run(s, n, k, c, (lim_off == NOLIM) ? NOLIM : s + lim_off);
        tick();
        bus.start    = 1'b0;
        // config changes during a run must have no effect
        bus.img_size = 8'd7;
        bus.ker_size = 8'd6;
        bus.num_ch   = 4'd9;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL %s: %0d expected events never seen, expected 0 left", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},    int'(bus.busy),    0);
        chk({tag, "_done"},    int'(bus.done),    0);
        chk({tag, "_cfg_err"}, int'(bus.cfg_err), 0);
        chk({tag, "_w_load"},  int'(bus.w_load),  0);
        chk({tag, "_i_load"},  int'(bus.i_load),  0);
        chk({tag, "_w_addr"},  int'(bus.w_addr),  0);
        chk({tag, "_i_addr"},  int'(bus.i_addr),  0);
        chk({tag, "_ch_idx"},  int'(bus.ch_idx),  0);
    endtask

    initial begin
        int s;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.img_size = 8'd0;
        bus.ker_size = 8'd0;
        bus.num_ch   = 4'd0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // case 1: N=14 K=3 C=1, done 212 cycles after start
        start_run(14, 3, 1, 1'b0, NOLIM, s);
        wait_empty("case1", 400);
`ifdef SA_LOAD_PERF_EN
        chk("perf_after_done", int'(bus.perf_cyc), 212);
        repeat (5) tick();
        chk("perf_hold", int'(bus.perf_cyc), 212);
`endif
        chk("case1_busy_after", int'(bus.busy), 0);
        tick();

        // case 2: N=4 K=2 C=3, done at cycle 79
        start_run(4, 2, 3, 1'b0, NOLIM, s);
        wait_empty("case2", 200);
        tick();

        // case 3: K>N and C=0 are rejected
        start_run(4, 5, 1, 1'b1, 0, s);
        chk("bad_k_busy", int'(bus.busy), 0);
        repeat (3) tick();
        chk("bad_k_busy_later", int'(bus.busy), 0);
        start_run(4, 2, 0, 1'b1, 0, s);
        chk("bad_c_busy", int'(bus.busy), 0);
        repeat (3) tick();
        wait_empty("case3", 10);

        // case 4: abort in ILD at i_addr=50, then a clean case-1 rerun
        start_run(14, 3, 1, 1'b0, 62, s);
        while (cyc < s + 62) tick();
        chk("abort_at_addr", int'(bus.i_addr), 50);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_i_load", int'(bus.i_load), 0);
        chk("abort_busy",   int'(bus.busy),   0);
        chk("abort_ch_idx", int'(bus.ch_idx), 0);
        chk("abort_i_addr_hold", int'(bus.i_addr), 50);
        repeat (200) tick();
        wait_empty("case4_abort", 5);
        start_run(14, 3, 1, 1'b0, NOLIM, s);
        wait_empty("case4_rerun", 400);
        tick();

        // case 5a: start pulsed mid-run is ignored
        start_run(4, 2, 2, 1'b0, NOLIM, s);
        repeat (10) tick();
        bus.img_size = 8'd8;
        bus.ker_size = 8'd2;
        bus.num_ch   = 4'd1;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        wait_empty("case5_ignore", 200);
        repeat (3) tick();

        // case 5b: rst_n low in the middle of WLD
        start_run(14, 3, 1, 1'b0, 2, s);
        while (cyc < s + 3) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        wait_empty("case5_reset", 5);
        chk("post_reset_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
